// File: rtl/ras_linked_stack.sv
// Return-address stack kept as a linked list of nodes taken from a free-list allocator.
// Pushes run every cycle; a pop that leaves a non-empty stack spends one extra cycle refilling the top register.
module ras_linked_stack #(
   parameter int ADDR  = 4,
   parameter int DEPTH = 16,
   parameter int WIDTH = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push,
   input  logic [WIDTH-1:0]  push_data,
   input  logic              pop,
   output logic              ready,
   output logic              top_valid,
   output logic [WIDTH-1:0]  top_data,
   output logic              pop_valid,
   output logic              empty,
   output logic              full,
   output logic [ADDR:0]     count,
   output logic              overflow,
   output logic              underflow,
   output logic              alloc,
   input  logic [ADDR-1:0]   alloc_addr,
   output logic              de_alloc,
   output logic [ADDR-1:0]   last_alloc_addr
);

   typedef enum logic {READY, REFILL} state_t;

   localparam logic [ADDR:0] DEPTH_C = (ADDR+1)'(DEPTH);
   localparam logic [ADDR:0] ONE_C   = (ADDR+1)'(1);

   state_t            state_reg;
   logic [ADDR-1:0]   top_ptr_reg;
   logic [WIDTH-1:0]  top_q_reg;
   logic [ADDR:0]     count_reg;
   logic              overflow_reg;

   logic [WIDTH-1:0]  data_mem [DEPTH];
   logic [WIDTH-1:0]  rd_data_reg;
   logic [ADDR-1:0]   link_reg [DEPTH];

   logic              is_ready;
   logic              is_empty;
   logic              is_full;
   logic              push_acc;
   logic              pop_acc;
   logic              replace;
   logic              pop_only;
   logic              refill_start;
   logic [ADDR-1:0]   next_top_ptr;
   logic              mem_we;
   logic [ADDR-1:0]   mem_waddr;

   always_comb begin
      is_ready     = (state_reg == READY);
      is_empty     = (count_reg == '0);
      is_full      = (count_reg == DEPTH_C);
      // A push paired with a pop on an empty stack still allocates a node.
      push_acc     = is_ready && push && (pop ? is_empty : !is_full);
      pop_acc      = is_ready && pop && !is_empty;
      replace      = pop_acc && push;
      pop_only     = pop_acc && !push;
      next_top_ptr = link_reg[top_ptr_reg];
      refill_start = pop_only && (count_reg != ONE_C);
      mem_we       = push_acc || replace;
      mem_waddr    = push_acc ? alloc_addr : top_ptr_reg;
   end

   // Node payload storage with a registered read port and write-first bypass.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         data_mem[mem_waddr] <= push_data;
      end
      if (refill_start) begin
         if (mem_we && (mem_waddr == next_top_ptr)) begin
            rd_data_reg <= push_data;
         end else begin
            rd_data_reg <= data_mem[next_top_ptr];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_acc) begin
         link_reg[alloc_addr] <= top_ptr_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg    <= READY;
         top_ptr_reg  <= '0;
         top_q_reg    <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         case (state_reg)
            READY: begin
               if (push_acc) begin
                  top_ptr_reg <= alloc_addr;
                  top_q_reg   <= push_data;
                  count_reg   <= count_reg + ONE_C;
               end else if (replace) begin
                  top_q_reg   <= push_data;
               end else if (pop_only) begin
                  top_ptr_reg <= next_top_ptr;
                  count_reg   <= count_reg - ONE_C;
                  if (refill_start) begin
                     state_reg <= REFILL;
                  end
               end
               if (push && !pop && is_full) begin
                  overflow_reg <= 1'b1;
               end
            end
            REFILL: begin
               top_q_reg <= rd_data_reg;
               state_reg <= READY;
            end
            default: state_reg <= READY;
         endcase
      end
   end

   always_comb begin
      ready           = is_ready;
      top_valid       = !is_empty && is_ready;
      top_data        = top_q_reg;
      pop_valid       = pop_acc;
      empty           = is_empty;
      full            = is_full;
      count           = count_reg;
      overflow        = overflow_reg;
      underflow       = is_ready && pop && is_empty;
      alloc           = push_acc;
      de_alloc        = pop_only;
      last_alloc_addr = top_ptr_reg;
   end

endmodule

// File: tb/tb_ras_linked_stack.sv
// Bench for ras_linked_stack: directed vector table, hand sequences for full/overflow and
// reset during refill, then random traffic against a queue-based stack model with a free-list allocator.
module tb_ras_linked_stack;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        push;
   logic [31:0] push_data;
   logic        pop;
   logic        ready;
   logic        top_valid;
   logic [31:0] top_data;
   logic        pop_valid;
   logic        empty;
   logic        full;
   logic [4:0]  count;
   logic        overflow;
   logic        underflow;
   logic        alloc;
   logic [3:0]  alloc_addr;
   logic        de_alloc;
   logic [3:0]  last_alloc_addr;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ras_linked_stack #(.ADDR(4), .DEPTH(16), .WIDTH(32)) dut (
      .clk(clk), .reset_n(reset_n), .push(push), .push_data(push_data), .pop(pop),
      .ready(ready), .top_valid(top_valid), .top_data(top_data), .pop_valid(pop_valid),
      .empty(empty), .full(full), .count(count), .overflow(overflow), .underflow(underflow),
      .alloc(alloc), .alloc_addr(alloc_addr), .de_alloc(de_alloc), .last_alloc_addr(last_alloc_addr)
   );

   typedef struct {
      logic        push;
      logic        pop;
      logic [31:0] din;
      logic [3:0]  aa;
      logic        rdy;
      logic        pv;
      logic        al;
      logic        da;
      logic        uf;
      logic [4:0]  cnt;
      logic        tv;
      logic [31:0] top;
      logic [3:0]  laa;
   } vec_t;

   vec_t tbl[21];

   function automatic vec_t mk(logic p, logic q, logic [31:0] d, logic [3:0] a, logic r, logic pv,
                               logic al, logic da, logic uf, logic [4:0] c, logic tv,
                               logic [31:0] t, logic [3:0] l);
      vec_t v;
      v.push = p; v.pop = q; v.din = d; v.aa = a; v.rdy = r; v.pv = pv; v.al = al;
      v.da = da; v.uf = uf; v.cnt = c; v.tv = tv; v.top = t; v.laa = l;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Inputs change just after the rising edge; outputs are then sampled on the falling edge.
   task automatic step(input logic p, input logic q, input logic [31:0] d, input logic [3:0] a);
      @(posedge clk);
      #1;
      push = p; pop = q; push_data = d; alloc_addr = a;
      @(negedge clk);
   endtask

   // Reference model state
   logic [31:0] stk[$];
   logic [3:0]  nodes[$];
   logic [3:0]  free_q[$];
   bit          busy;
   bit          ovf;

   initial begin
      reset_n = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0; alloc_addr = '0;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("reset_ready", 32'(ready), 1);
      chk("reset_count", 32'(count), 0);
      chk("reset_overflow", 32'(overflow), 0);
      chk("reset_top_valid", 32'(top_valid), 0);
      chk("reset_top_data", top_data, 0);
      chk("reset_empty", 32'(empty), 1);
      chk("reset_pulses", {28'd0, alloc, de_alloc, pop_valid, underflow}, 0);
      $display("reset: ready=%0b count=%0d", ready, count);
      reset_n = 1'b1;

      //          push pop din        aa  rdy pv al da uf cnt tv top        laa
      tbl[0]  = mk(1, 0, 32'h100,  3, 1, 0, 1, 0, 0, 0, 0, 32'h0,   0);
      tbl[1]  = mk(1, 0, 32'h200,  7, 1, 0, 1, 0, 0, 1, 1, 32'h100, 0);
      tbl[2]  = mk(1, 0, 32'h300,  2, 1, 0, 1, 0, 0, 2, 1, 32'h200, 0);
      tbl[3]  = mk(0, 0, 32'h0,    0, 1, 0, 0, 0, 0, 3, 1, 32'h300, 0);
      tbl[4]  = mk(0, 1, 32'h0,    0, 1, 1, 0, 1, 0, 3, 1, 32'h300, 2);
      tbl[5]  = mk(0, 1, 32'h0,    0, 0, 0, 0, 0, 0, 2, 0, 32'h0,   0);
      tbl[6]  = mk(0, 1, 32'h0,    0, 1, 1, 0, 1, 0, 2, 1, 32'h200, 7);
      tbl[7]  = mk(0, 0, 32'h0,    0, 0, 0, 0, 0, 0, 1, 0, 32'h0,   0);
      tbl[8]  = mk(0, 1, 32'h0,    0, 1, 1, 0, 1, 0, 1, 1, 32'h100, 3);
      tbl[9]  = mk(0, 0, 32'h0,    0, 1, 0, 0, 0, 0, 0, 0, 32'h0,   0);
      tbl[10] = mk(0, 1, 32'h0,    0, 1, 0, 0, 0, 1, 0, 0, 32'h0,   0);
      tbl[11] = mk(1, 1, 32'h55,   5, 1, 0, 1, 0, 1, 0, 0, 32'h0,   0);
      tbl[12] = mk(0, 0, 32'h0,    0, 1, 0, 0, 0, 0, 1, 1, 32'h55,  0);
      tbl[13] = mk(1, 0, 32'h200,  9, 1, 0, 1, 0, 0, 1, 1, 32'h55,  0);
      tbl[14] = mk(1, 1, 32'hABC,  4, 1, 1, 0, 0, 0, 2, 1, 32'h200, 0);
      tbl[15] = mk(0, 0, 32'h0,    0, 1, 0, 0, 0, 0, 2, 1, 32'hABC, 0);
      tbl[16] = mk(0, 1, 32'h0,    0, 1, 1, 0, 1, 0, 2, 1, 32'hABC, 9);
      tbl[17] = mk(0, 0, 32'h0,    0, 0, 0, 0, 0, 0, 1, 0, 32'h0,   0);
      tbl[18] = mk(0, 0, 32'h0,    0, 1, 0, 0, 0, 0, 1, 1, 32'h55,  0);
      tbl[19] = mk(0, 1, 32'h0,    0, 1, 1, 0, 1, 0, 1, 1, 32'h55,  5);
      tbl[20] = mk(0, 0, 32'h0,    0, 1, 0, 0, 0, 0, 0, 0, 32'h0,   0);

      for (int i = 0; i < 21; i++) begin
         step(tbl[i].push, tbl[i].pop, tbl[i].din, tbl[i].aa);
         chk("vec_ready", 32'(ready), 32'(tbl[i].rdy));
         chk("vec_pop_valid", 32'(pop_valid), 32'(tbl[i].pv));
         chk("vec_alloc", 32'(alloc), 32'(tbl[i].al));
         chk("vec_de_alloc", 32'(de_alloc), 32'(tbl[i].da));
         chk("vec_underflow", 32'(underflow), 32'(tbl[i].uf));
         chk("vec_count", 32'(count), 32'(tbl[i].cnt));
         chk("vec_empty", 32'(empty), 32'(tbl[i].cnt == 0));
         chk("vec_top_valid", 32'(top_valid), 32'(tbl[i].tv));
         if (tbl[i].tv || tbl[i].pv) chk("vec_top_data", top_data, tbl[i].top);
         if (tbl[i].da) chk("vec_last_alloc_addr", 32'(last_alloc_addr), 32'(tbl[i].laa));
         $display("vec %0d: push=%0b pop=%0b count=%0d top=0x%0h pv=%0b alloc=%0b de_alloc=%0b",
                  i, push, pop, count, top_data, pop_valid, alloc, de_alloc);
      end

      // Fill to capacity, then overflow.
      for (int i = 0; i < 16; i++) begin
         step(1, 0, 32'h1000 + 32'(i), 4'(i));
         chk("fill_alloc", 32'(alloc), 1);
         chk("fill_count", 32'(count), 32'(i));
         $display("fill %0d: count=%0d alloc=%0b", i, count, alloc);
      end
      step(1, 0, 32'hDEAD, 0);
      chk("full_flag", 32'(full), 1);
      chk("full_count", 32'(count), 16);
      chk("full_push_alloc", 32'(alloc), 0);
      $display("push on full: full=%0b alloc=%0b", full, alloc);
      step(0, 1, 0, 0);
      chk("overflow_set", 32'(overflow), 1);
      chk("overflow_top_data", top_data, 32'h100F);
      chk("overflow_pop_valid", 32'(pop_valid), 1);
      chk("overflow_pop_laa", 32'(last_alloc_addr), 15);
      $display("pop after overflow: overflow=%0b top=0x%0h", overflow, top_data);
      step(0, 0, 0, 0);
      chk("after_pop_full", 32'(full), 0);
      chk("after_pop_overflow", 32'(overflow), 1);
      chk("after_pop_ready", 32'(ready), 0);
      chk("after_pop_count", 32'(count), 15);
      step(0, 0, 0, 0);
      chk("refill_top_valid", 32'(top_valid), 1);
      chk("refill_top_data", top_data, 32'h100E);
      chk("overflow_sticky", 32'(overflow), 1);
      $display("refilled: top=0x%0h overflow=%0b", top_data, overflow);

      // Reset asserted while the stack is refilling.
      step(0, 1, 0, 0);
      chk("pre_reset_pop_top", top_data, 32'h100E);
      chk("pre_reset_pop_laa", 32'(last_alloc_addr), 14);
      step(0, 0, 0, 0);
      chk("in_refill_ready", 32'(ready), 0);
      reset_n = 1'b0;
      step(0, 0, 0, 0);
      chk("midreset_ready", 32'(ready), 1);
      chk("midreset_count", 32'(count), 0);
      chk("midreset_overflow", 32'(overflow), 0);
      chk("midreset_top_valid", 32'(top_valid), 0);
      $display("reset in refill: ready=%0b count=%0d overflow=%0b", ready, count, overflow);
      reset_n = 1'b1;
      step(1, 0, 32'h10, 6);
      chk("post_reset_alloc", 32'(alloc), 1);
      step(0, 0, 0, 0);
      chk("post_reset_count", 32'(count), 1);
      chk("post_reset_top", top_data, 32'h10);
      chk("post_reset_top_valid", 32'(top_valid), 1);
      $display("push after reset: count=%0d top=0x%0h", count, top_data);

      // Random traffic against the reference model.
      reset_n = 1'b0;
      step(0, 0, 0, 0);
      reset_n = 1'b1;
      stk.delete(); nodes.delete(); free_q.delete();
      for (int i = 0; i < 16; i++) free_q.push_back(4'((i * 5 + 3) % 16));
      busy = 0; ovf = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         int          pb;
         int          qb;
         logic        p;
         logic        q;
         logic [31:0] d;
         logic [3:0]  a;
         int          n;
         bit          e_rdy, e_pv, e_al, e_da, e_uf, e_rep, e_tv;
         logic [3:0]  e_laa;
         pb = (cyc < 500) ? 70 : (cyc < 1000) ? 50 : 25;
         qb = (cyc < 500) ? 30 : (cyc < 1000) ? 50 : 70;
         p = ($urandom_range(0, 99) < pb);
         q = ($urandom_range(0, 99) < qb);
         d = $urandom;
         a = (free_q.size() > 0) ? free_q[0] : 4'd0;
         step(p, q, d, a);

         n = stk.size();
         e_rdy = !busy; e_pv = 0; e_al = 0; e_da = 0; e_uf = 0; e_rep = 0; e_laa = 0;
         e_tv = (n > 0) && !busy;
         if (e_rdy) begin
            if (p && q && n > 0) begin
               e_pv = 1; e_rep = 1;
            end else if (p) begin
               if (q) e_uf = 1;
               if (n < 16) e_al = 1;
            end else if (q) begin
               if (n > 0) begin
                  e_pv = 1; e_da = 1; e_laa = nodes[n-1];
               end else begin
                  e_uf = 1;
               end
            end
         end
         chk("rand_ready", 32'(ready), 32'(e_rdy));
         chk("rand_pop_valid", 32'(pop_valid), 32'(e_pv));
         chk("rand_alloc", 32'(alloc), 32'(e_al));
         chk("rand_de_alloc", 32'(de_alloc), 32'(e_da));
         chk("rand_underflow", 32'(underflow), 32'(e_uf));
         chk("rand_count", 32'(count), 32'(n));
         chk("rand_full", 32'(full), 32'(n == 16));
         chk("rand_top_valid", 32'(top_valid), 32'(e_tv));
         chk("rand_overflow", 32'(overflow), 32'(ovf));
         if (e_pv || e_tv) chk("rand_top_data", top_data, stk[n-1]);
         if (e_da) chk("rand_last_alloc_addr", 32'(last_alloc_addr), 32'(e_laa));
         $display("rand %0d: push=%0b pop=%0b count=%0d pv=%0b alloc=%0b de_alloc=%0b",
                  cyc, p, q, count, pop_valid, alloc, de_alloc);

         busy = 0;
         if (e_rdy && p && !q && n == 16) ovf = 1;
         if (e_rep) stk[n-1] = d;
         if (e_al) begin
            stk.push_back(d);
            nodes.push_back(a);
            void'(free_q.pop_front());
         end
         if (e_da) begin
            void'(stk.pop_back());
            void'(nodes.pop_back());
            free_q.push_back(e_laa);
            busy = (n > 1);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
